// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: anode select codes, active-low GFEDCBA
// segment patterns, character codes and decode helpers. Used by both the
// display drivers and the scan-bus decoder.
package seg7_pkg;

  // Active-low one-hot anode selects; AN_POS3 is the leftmost digit
  localparam logic [3:0] AN_POS0  = 4'b1110;
  localparam logic [3:0] AN_POS1  = 4'b1101;
  localparam logic [3:0] AN_POS2  = 4'b1011;
  localparam logic [3:0] AN_POS3  = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Segment patterns, bit order GFEDCBA, 0 = lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Character codes beyond the decimal digits
  localparam logic [3:0] CH_DASH  = 4'd10;
  localparam logic [3:0] CH_BAD   = 4'd14;
  localparam logic [3:0] CH_BLANK = 4'd15;

  // Frame assembly FSM states
  typedef enum logic {
    FR_IDLE    = 1'b0,
    FR_COLLECT = 1'b1
  } frame_state_e;

  // Segment pattern to character code; unknown patterns map to CH_BAD
  function automatic logic [3:0] seg_to_code(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_DASH:  code = CH_DASH;
      SEG_BLANK: code = CH_BLANK;
      default:   code = CH_BAD;
    endcase
    return code;
  endfunction

  // Anode select to {valid, position}; valid is 0 for blanking and illegal codes
  function automatic logic [2:0] anode_to_pos(input logic [3:0] an);
    logic [2:0] res;
    case (an)
      AN_POS0: res = 3'b100;
      AN_POS1: res = 3'b101;
      AN_POS2: res = 3'b110;
      AN_POS3: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_sample_filter.sv
// Synchronizes the asynchronous scan bus and filters anode-switch ghosting:
// a pattern is accepted once, after it has been seen STABLE_CYCLES times in a
// row, and is not accepted again until the bus shows a different pattern.
module seg7_sample_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic [6:0] display_in,
  output logic       accept,
  output logic [3:0] digit,
  output logic [6:0] display
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [10:0]   sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_q;

  // Run length of the synchronized pattern, saturating at STABLE_CYCLES
  always_comb begin
    cnt_d = CW'(1);
    if (sync1_q == sync2_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Synchronizer chain, run counter and single-shot accept strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      sync1_q  <= {digit_in, display_in};
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      accept_q <= (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end
  end

  // The accepted pattern is still held in sync2 during the accept cycle
  assign accept  = accept_q;
  assign digit   = sync2_q[10:7];
  assign display = sync2_q[6:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops the multiplexed active-low 7-segment scan bus and rebuilds complete
// four-character frames. frame_valid is a one-cycle strobe with no
// backpressure: char3..char0 change only in that cycle and hold until the
// next strobe; frame_changed is meaningful only while frame_valid is high.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 65536
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   digit_in,
  input  logic [6:0]   display_in,
  output logic [3:0]   char3,
  output logic [3:0]   char2,
  output logic [3:0]   char1,
  output logic [3:0]   char0,
  output logic         frame_valid,
  output logic         frame_changed,
  output logic         scan_err,
  output logic         seg_err,
  output logic         frame_err,
  output frame_state_e frame_state
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(FRAME_TIMEOUT);

  logic       accept;
  logic [3:0] smp_digit;
  logic [6:0] smp_display;

  seg7_sample_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .display_in (display_in),
    .accept     (accept),
    .digit      (smp_digit),
    .display    (smp_display)
  );

  frame_state_e    state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] chars_q, chars_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            fv_d, fc_d, scan_err_d, seg_err_d, ferr_d;
  logic            fv_q, fc_q, scan_err_q, seg_err_q, ferr_q;
  logic [2:0]      an_dec;
  logic [3:0]      code;
  logic [1:0]      pos;
  logic [3:0]      onehot;
  logic            dig_ok;

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FR_IDLE;
    else      state_q <= state_d;
  end

  // Decode the accepted pattern and advance frame assembly
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    shadow_d   = shadow_q;
    chars_d    = chars_q;
    tcnt_d     = tcnt_q;
    fv_d       = 1'b0;
    fc_d       = 1'b0;
    an_dec     = anode_to_pos(smp_digit);
    code       = seg_to_code(smp_display);
    pos        = an_dec[1:0];
    onehot     = 4'b0001 << pos;
    dig_ok     = accept && an_dec[2];
    scan_err_d = accept && !an_dec[2] && (smp_digit != AN_BLANK);
    seg_err_d  = dig_ok && (code == CH_BAD);
    ferr_d     = 1'b0;
    case (state_q)
      FR_IDLE: begin
        tcnt_d = '0;
        if (dig_ok) begin
          shadow_d[pos] = code;
          mask_d        = onehot;
          state_d       = FR_COLLECT;
        end
      end
      FR_COLLECT: begin
        if (dig_ok) begin
          // An accepted digit always wins over a coincident timeout
          tcnt_d        = '0;
          shadow_d[pos] = code;
          if (mask_q[pos]) begin
            // Position seen twice: the scan restarted, begin a new frame here
            mask_d = onehot;
          end else if ((mask_q | onehot) == 4'hF) begin
            chars_d = shadow_d;
            fv_d    = 1'b1;
            fc_d    = (shadow_d != chars_q);
            mask_d  = '0;
            state_d = FR_IDLE;
          end else begin
            mask_d = mask_q | onehot;
          end
        end else if (tcnt_q == TMAX) begin
          ferr_d  = 1'b1;
          mask_d  = '0;
          tcnt_d  = '0;
          state_d = FR_IDLE;
        end else begin
          // Never passes TMAX: reaching it leaves COLLECT and clears the count
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = FR_IDLE;
    endcase
  end

  // Frame datapath and registered status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q     <= '0;
      shadow_q   <= '1;
      chars_q    <= '1;
      tcnt_q     <= '0;
      fv_q       <= 1'b0;
      fc_q       <= 1'b0;
      scan_err_q <= 1'b0;
      seg_err_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      chars_q    <= chars_d;
      tcnt_q     <= tcnt_d;
      fv_q       <= fv_d;
      fc_q       <= fc_d;
      scan_err_q <= scan_err_d;
      seg_err_q  <= seg_err_d;
      ferr_q     <= ferr_d;
    end
  end

  assign char3         = chars_q[3];
  assign char2         = chars_q[2];
  assign char1         = chars_q[1];
  assign char0         = chars_q[0];
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign scan_err      = scan_err_q;
  assign seg_err       = seg_err_q;
  assign frame_err     = ferr_q;
  assign frame_state   = state_q;

endmodule
